// File: rtl/apb_uart_pkg.sv
// Shared types and bus widths for the UART register-block APB path.
package apb_uart_pkg;

  localparam int unsigned APB_ADDR_W = 12;
  localparam int unsigned APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_mst_state_e;

endpackage

// File: rtl/apb_host_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: on a tie the requester that did not win last time is granted.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       en,
  output logic [1:0] gnt
);

  // One-hot grant; requester 0 wins a tie when requester 1 was granted last
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req[0] && (!req[1] || last_grant)) begin
        gnt = 2'b01;
      end else if (req[1]) begin
        gnt = 2'b10;
      end
    end
  end

endmodule

// File: rtl/apb_host_arbiter.sv
// Two-requester APB4 master in front of the UART register block: round-robin
// arbitration, SETUP/ACCESS sequencing, pready timeout and response return.
module apb_host_arbiter
  import apb_uart_pkg::*;
#(
  parameter int unsigned ADDR_W         = APB_ADDR_W,
  parameter int unsigned DATA_W         = APB_DATA_W,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                    pclk,
  input  logic                    preset,
  input  logic [1:0]              req_valid,
  input  logic [1:0]              req_write,
  input  logic [2*ADDR_W-1:0]     req_addr,
  input  logic [2*DATA_W-1:0]     req_wdata,
  input  logic [2*(DATA_W/8)-1:0] req_strb,
  output logic [1:0]              req_ready,
  output logic [1:0]              rsp_valid,
  output logic [DATA_W-1:0]       rsp_rdata,
  output logic                    rsp_err,
  output logic                    psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic [ADDR_W-1:0]       paddr,
  output logic [DATA_W-1:0]       pwdata,
  output logic [DATA_W/8-1:0]     pstrb,
  input  logic                    pready,
  input  logic                    pslverr,
  input  logic [DATA_W-1:0]       prdata,
  output logic                    busy,
  output logic                    timeout_evt
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned CNT_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  apb_mst_state_e      state;
  logic                last_grant;
  logic                owner_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   strb_q;
  logic                write_q;
  logic [CNT_W-1:0]    cnt_q;

  logic [1:0]          gnt;
  logic                sel_write;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic [STRB_W-1:0]   sel_strb;
  logic [1:0]          owner_onehot;

  rr_arb2 u_arb (
    .req        (req_valid),
    .last_grant (last_grant),
    .en         (state == IDLE),
    .gnt        (gnt)
  );

  assign req_ready    = gnt;
  assign owner_onehot = {owner_q, ~owner_q};

  // Pick the granted requester's payload for latching
  always_comb begin
    sel_write = req_write[0];
    sel_addr  = req_addr[0 +: ADDR_W];
    sel_wdata = req_wdata[0 +: DATA_W];
    sel_strb  = req_strb[0 +: STRB_W];
    if (gnt[1]) begin
      sel_write = req_write[1];
      sel_addr  = req_addr[ADDR_W +: ADDR_W];
      sel_wdata = req_wdata[DATA_W +: DATA_W];
      sel_strb  = req_strb[STRB_W +: STRB_W];
    end
  end

  // APB outputs decoded from state and latched payload only; zero while idle
  assign busy    = (state != IDLE);
  assign psel    = busy;
  assign penable = (state == ACCESS);
  assign pwrite  = busy & write_q;
  assign paddr   = busy ? addr_q  : '0;
  assign pwdata  = busy ? wdata_q : '0;
  assign pstrb   = busy ? strb_q  : '0;

  // Transfer FSM, payload latches, timeout counter and response registers
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      owner_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      strb_q      <= '0;
      write_q     <= 1'b0;
      cnt_q       <= '0;
      rsp_valid   <= '0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      timeout_evt <= 1'b0;
    end else begin
      rsp_valid   <= '0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      timeout_evt <= 1'b0;
      case (state)
        IDLE: begin
          if (|gnt) begin
            owner_q    <= gnt[1];
            last_grant <= gnt[1];
            addr_q     <= sel_addr;
            write_q    <= sel_write;
            // Reads never drive write data or strobes onto the bus
            wdata_q    <= sel_write ? sel_wdata : '0;
            strb_q     <= sel_write ? sel_strb  : '0;
            state      <= SETUP;
          end
        end
        SETUP: begin
          cnt_q <= '0;
          state <= ACCESS;
        end
        ACCESS: begin
          if (pready) begin
            rsp_valid <= owner_onehot;
            rsp_err   <= pslverr;
            rsp_rdata <= write_q ? '0 : prdata;
            state     <= IDLE;
          end else if (cnt_q == CNT_LAST) begin
            rsp_valid   <= owner_onehot;
            rsp_err     <= 1'b1;
            timeout_evt <= 1'b1;
            state       <= IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_host_arbiter.sv
// Self-checking bench for apb_host_arbiter: directed scenarios plus randomized
// two-requester traffic against a transaction-level reference model.
module tb_apb_host_arbiter;

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;

  logic          pclk;
  logic          preset;
  logic [1:0]    req_valid;
  logic [1:0]    req_write;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [2*SW-1:0] req_strb;
  logic [1:0]    req_ready;
  logic [1:0]    rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          psel;
  logic          penable;
  logic          pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic [SW-1:0] pstrb;
  logic          pready;
  logic          pslverr;
  logic [DW-1:0] prdata;
  logic          busy;
  logic          timeout_evt;

  int n_checks = 0;
  int n_errors = 0;

  // Slave configuration
  bit            slv_auto = 1'b0;
  bit            slv_err  = 1'b0;
  bit            slv_hang = 1'b0;
  int            slv_wait = 0;
  logic [DW-1:0] slv_rdata = '0;
  int            acc_cnt = 0;

  apb_host_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(16)
  ) dut (
    .pclk(pclk), .preset(preset),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_strb(req_strb), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pstrb(pstrb), .pready(pready), .pslverr(pslverr),
    .prdata(prdata), .busy(busy), .timeout_evt(timeout_evt)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Behavioural APB slave: waits, error and data either programmed or derived from paddr
  always @(negedge pclk) begin : slave_model
    int w;
    logic e;
    logic [DW-1:0] d;
    if (psel && penable) begin
      if (slv_auto) begin
        w = int'(paddr[1:0]);
        e = (paddr[AW-1:AW-2] == 2'b11);
        d = {8'hC3, paddr, paddr};
      end else begin
        w = slv_wait;
        e = slv_err;
        d = slv_rdata;
      end
      pready  = (acc_cnt >= w) && !slv_hang;
      pslverr = pready ? e : 1'b1;
      prdata  = pready ? d : 32'hDEAD_BEEF;
      acc_cnt++;
    end else begin
      pready  = 1'b0;
      pslverr = 1'b0;
      prdata  = '0;
      acc_cnt = 0;
    end
  end

  task automatic step();
    @(negedge pclk);
    #1;
  endtask

  task automatic apply_reset();
    step();
    preset    = 1'b1;
    req_valid = '0;
    step();
    step();
    preset = 1'b0;
  endtask

  task automatic set_req(input int i, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [SW-1:0] s);
    req_write[i]           = wr;
    req_addr[i*AW +: AW]   = a;
    req_wdata[i*DW +: DW]  = d;
    req_strb[i*SW +: SW]   = s;
    req_valid[i]           = 1'b1;
  endtask

  task automatic test_reset();
    logic [AW+DW+SW+DW+9:0] outs;
    preset = 1'b1;
    step();
    outs = {psel, penable, pwrite, paddr, pwdata, pstrb, req_ready, rsp_valid,
            rsp_rdata, rsp_err, busy, timeout_evt};
    n_checks++;
    if (outs !== '0) begin n_errors++; $display("FAIL reset_outputs: got %h expected 0", outs); end
    preset = 1'b0;
    step();
    n_checks++;
    if ({busy, psel, rsp_valid} !== 4'b0) begin
      n_errors++; $display("FAIL reset_idle: got %b expected 0000", {busy, psel, rsp_valid});
    end
  endtask

  task automatic test_single_write();
    slv_auto = 0; slv_wait = 0; slv_err = 0; slv_hang = 0;
    step();
    set_req(0, 1'b1, 12'h004, 32'hA5A5_0001, 4'hF);
    #1;
    n_checks++;
    if (req_ready !== 2'b01) begin n_errors++; $display("FAIL wr_accept: got %b expected 01", req_ready); end
    step();
    set_req(1, 1'b0, 12'h7F0, 32'h1234_5678, 4'h5);
    #1;
    n_checks++;
    if (req_ready !== 2'b00) begin n_errors++; $display("FAIL wr_no_accept_busy: got %b expected 00", req_ready); end
    n_checks++;
    if ({psel, penable, pwrite, paddr, pwdata, pstrb} !== {3'b101, 12'h004, 32'hA5A5_0001, 4'hF}) begin
      n_errors++;
      $display("FAIL wr_setup: got %h expected %h", {psel, penable, pwrite, paddr, pwdata, pstrb},
               {3'b101, 12'h004, 32'hA5A5_0001, 4'hF});
    end
    step();
    n_checks++;
    if ({psel, penable, paddr} !== {2'b11, 12'h004}) begin
      n_errors++; $display("FAIL wr_access: got %h expected %h", {psel, penable, paddr}, {2'b11, 12'h004});
    end
    req_valid = '0;
    step();
    n_checks++;
    if ({rsp_valid, rsp_err, rsp_rdata, psel, timeout_evt} !== {2'b01, 1'b0, 32'h0, 1'b0, 1'b0}) begin
      n_errors++;
      $display("FAIL wr_rsp: got %h expected %h", {rsp_valid, rsp_err, rsp_rdata, psel, timeout_evt},
               {2'b01, 1'b0, 32'h0, 1'b0, 1'b0});
    end
    step();
    n_checks++;
    if (rsp_valid !== 2'b00) begin n_errors++; $display("FAIL wr_rsp_pulse: got %b expected 00", rsp_valid); end
  endtask

  task automatic test_single_read_wait();
    slv_auto = 0; slv_wait = 1; slv_err = 0; slv_hang = 0; slv_rdata = 32'h0000_0055;
    step();
    set_req(1, 1'b0, 12'h010, 32'hFFFF_FFFF, 4'hF);
    #1;
    n_checks++;
    if (req_ready !== 2'b10) begin n_errors++; $display("FAIL rd_accept: got %b expected 10", req_ready); end
    for (int k = 1; k <= 3; k++) begin
      step();
      if (k == 1) req_valid = '0;
      n_checks++;
      if ({psel, penable, pwrite, paddr, pwdata, pstrb, rsp_valid} !==
          {1'b1, (k > 1), 1'b0, 12'h010, 32'h0, 4'h0, 2'b00}) begin
        n_errors++;
        $display("FAIL rd_bus_cycle%0d: got %h expected %h", k,
                 {psel, penable, pwrite, paddr, pwdata, pstrb, rsp_valid},
                 {1'b1, (k > 1), 1'b0, 12'h010, 32'h0, 4'h0, 2'b00});
      end
    end
    step();
    n_checks++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 1'b0, 32'h0000_0055}) begin
      n_errors++;
      $display("FAIL rd_rsp: got %h expected %h", {rsp_valid, rsp_err, rsp_rdata}, {2'b10, 1'b0, 32'h0000_0055});
    end
  endtask

  task automatic test_contention();
    int grants[$];
    int acc_at[$];
    logic psel_at[$];
    apply_reset();
    slv_auto = 0; slv_wait = 0; slv_err = 0; slv_hang = 0;
    step();
    set_req(0, 1'b1, 12'h100, 32'h1111_0000, 4'hF);
    set_req(1, 1'b1, 12'h200, 32'h2222_0000, 4'h3);
    for (int c = 0; c < 40 && grants.size() < 4; c++) begin
      if (c > 0) step();
      #1;
      if (req_ready != 2'b00) begin
        grants.push_back(int'(req_ready[1]));
        acc_at.push_back(c);
        psel_at.push_back(psel);
      end
    end
    step();
    req_valid = '0;
    n_checks++;
    if (grants.size() != 4) begin
      n_errors++; $display("FAIL cont_count: got %0d expected 4", grants.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (grants[k] != k % 2) begin
          n_errors++; $display("FAIL cont_order%0d: got %0d expected %0d", k, grants[k], k % 2);
        end
        n_checks++;
        if (psel_at[k] !== 1'b0) begin
          n_errors++; $display("FAIL cont_gap%0d: got psel %b expected 0", k, psel_at[k]);
        end
        if (k > 0) begin
          n_checks++;
          if (acc_at[k] - acc_at[k-1] != 3) begin
            n_errors++; $display("FAIL cont_spacing%0d: got %0d expected 3", k, acc_at[k] - acc_at[k-1]);
          end
        end
      end
    end
    repeat (4) step();
  endtask

  task automatic test_slave_error();
    int evts = 0;
    slv_auto = 0; slv_wait = 0; slv_err = 1; slv_hang = 0;
    step();
    set_req(0, 1'b1, 12'hFFC, 32'h0BAD_0BAD, 4'hF);
    step();
    req_valid = '0;
    step();
    step();
    n_checks++;
    if ({rsp_valid, rsp_err} !== 3'b011) begin
      n_errors++; $display("FAIL err_rsp: got %b expected 011", {rsp_valid, rsp_err});
    end
    if (timeout_evt) evts++;
    step();
    if (timeout_evt) evts++;
    n_checks++;
    if (evts != 0) begin n_errors++; $display("FAIL err_no_timeout: got %0d expected 0", evts); end
    slv_err = 0;
  endtask

  task automatic test_timeout();
    int accesses = 0;
    bit seen = 1'b0;
    slv_auto = 0; slv_hang = 1;
    step();
    set_req(1, 1'b0, 12'h020, 32'h0, 4'h0);
    step();
    req_valid = '0;
    for (int c = 0; c < 40 && !seen; c++) begin
      step();
      if (psel && penable) accesses++;
      if (rsp_valid != 2'b00) begin
        seen = 1'b1;
        n_checks++;
        if ({psel, rsp_valid, rsp_err, rsp_rdata, timeout_evt} !== {1'b0, 2'b10, 1'b1, 32'h0, 1'b1}) begin
          n_errors++;
          $display("FAIL to_rsp: got %h expected %h", {psel, rsp_valid, rsp_err, rsp_rdata, timeout_evt},
                   {1'b0, 2'b10, 1'b1, 32'h0, 1'b1});
        end
      end
    end
    n_checks++;
    if (!seen) begin n_errors++; $display("FAIL to_no_response: got none expected rsp within 40 cycles"); end
    n_checks++;
    if (accesses != 16) begin n_errors++; $display("FAIL to_access_cycles: got %0d expected 16", accesses); end
    step();
    n_checks++;
    if ({timeout_evt, rsp_valid} !== 3'b000) begin
      n_errors++; $display("FAIL to_pulse: got %b expected 000", {timeout_evt, rsp_valid});
    end
    slv_hang = 0;
  endtask

  task automatic test_reset_mid();
    int rsps = 0;
    slv_auto = 0; slv_wait = 5; slv_err = 0; slv_hang = 0;
    step();
    set_req(1, 1'b1, 12'h0A0, 32'hCAFE_F00D, 4'hF);
    step();
    req_valid = '0;
    step();
    step();
    preset = 1'b1;
    #1;
    n_checks++;
    if ({psel, penable, pwrite, paddr, busy, rsp_valid} !== '0) begin
      n_errors++;
      $display("FAIL rstmid_async: got %h expected 0", {psel, penable, pwrite, paddr, busy, rsp_valid});
    end
    step();
    if (rsp_valid != 2'b00) rsps++;
    preset = 1'b0;
    slv_wait = 0;
    step();
    if (rsp_valid != 2'b00) rsps++;
    n_checks++;
    if (rsps != 0) begin n_errors++; $display("FAIL rstmid_no_rsp: got %0d expected 0", rsps); end
    set_req(0, 1'b0, 12'h0B0, 32'h0, 4'h0);
    set_req(1, 1'b0, 12'h0C0, 32'h0, 4'h0);
    #1;
    n_checks++;
    if (req_ready !== 2'b01) begin n_errors++; $display("FAIL rstmid_first_grant: got %b expected 01", req_ready); end
    step();
    req_valid = '0;
    step();
    step();
    n_checks++;
    if (rsp_valid !== 2'b01) begin n_errors++; $display("FAIL rstmid_rsp: got %b expected 01", rsp_valid); end
  endtask

  // Randomized traffic against a transaction-level model of grant order, bus window and response
  task automatic test_random();
    logic [AW-1:0] g_a[2];
    logic          g_w[2];
    logic [DW-1:0] g_d[2];
    logic [SW-1:0] g_s[2];
    int            remaining[2];
    bit            drop[2];
    bit            m_last, inflight, finished, owner;
    int            acc_c, done_c;
    logic [AW-1:0] o_a;
    logic          o_w;
    logic [DW-1:0] o_d;
    logic [SW-1:0] o_s;
    logic [1:0]    exp_ready, exp_rsp;
    logic          exp_psel, exp_pen;
    apply_reset();
    slv_auto = 1; slv_hang = 0;
    m_last = 1'b1; inflight = 1'b0; finished = 1'b0; owner = 1'b0;
    remaining[0] = 30; remaining[1] = 30; drop[0] = 1'b0; drop[1] = 1'b0;
    acc_c = 0; done_c = 0; o_a = '0; o_w = 1'b0; o_d = '0; o_s = '0;
    for (int c = 0; c < 3000; c++) begin
      step();
      for (int i = 0; i < 2; i++) begin
        if (drop[i]) begin req_valid[i] = 1'b0; drop[i] = 1'b0; end
        if (!req_valid[i] && remaining[i] > 0 && $urandom_range(0, 3) != 0) begin
          g_w[i] = 1'($urandom);
          g_a[i] = AW'($urandom);
          g_d[i] = $urandom;
          g_s[i] = SW'($urandom);
          set_req(i, g_w[i], g_a[i], g_d[i], g_s[i]);
          remaining[i]--;
        end
      end
      #1;
      exp_psel = inflight && (c > acc_c) && (c < done_c);
      exp_pen  = exp_psel && (c > acc_c + 1);
      n_checks++;
      if ({psel, penable} !== {exp_psel, exp_pen}) begin
        n_errors++; $display("FAIL rnd_psel_pen c%0d: got %b expected %b", c, {psel, penable}, {exp_psel, exp_pen});
      end
      if (inflight && c == acc_c + 1) begin
        n_checks++;
        if ({paddr, pwrite, pwdata, pstrb} !== {o_a, o_w, (o_w ? o_d : 32'h0), (o_w ? o_s : 4'h0)}) begin
          n_errors++;
          $display("FAIL rnd_setup c%0d: got %h expected %h", c, {paddr, pwrite, pwdata, pstrb},
                   {o_a, o_w, (o_w ? o_d : 32'h0), (o_w ? o_s : 4'h0)});
        end
      end
      exp_rsp = (inflight && c == done_c) ? (owner ? 2'b10 : 2'b01) : 2'b00;
      n_checks++;
      if (rsp_valid !== exp_rsp) begin
        n_errors++; $display("FAIL rnd_rsp_valid c%0d: got %b expected %b", c, rsp_valid, exp_rsp);
      end
      if (exp_rsp != 2'b00) begin
        n_checks++;
        if ({rsp_err, rsp_rdata} !== {(o_a[AW-1:AW-2] == 2'b11), (o_w ? 32'h0 : {8'hC3, o_a, o_a})}) begin
          n_errors++;
          $display("FAIL rnd_rsp_data c%0d: got %h expected %h", c, {rsp_err, rsp_rdata},
                   {(o_a[AW-1:AW-2] == 2'b11), (o_w ? 32'h0 : {8'hC3, o_a, o_a})});
        end
        inflight = 1'b0;
      end
      exp_ready = 2'b00;
      if (!inflight) begin
        if (req_valid == 2'b11) exp_ready = m_last ? 2'b01 : 2'b10;
        else                    exp_ready = req_valid;
      end
      n_checks++;
      if (req_ready !== exp_ready) begin
        n_errors++; $display("FAIL rnd_ready c%0d: got %b expected %b", c, req_ready, exp_ready);
      end
      if (exp_ready != 2'b00) begin
        owner    = exp_ready[1];
        m_last   = exp_ready[1];
        inflight = 1'b1;
        o_a = g_a[owner]; o_w = g_w[owner]; o_d = g_d[owner]; o_s = g_s[owner];
        acc_c  = c;
        done_c = c + 3 + int'(o_a[1:0]);
        drop[owner] = 1'b1;
      end
      if (remaining[0] == 0 && remaining[1] == 0 && req_valid == 2'b00 && !inflight) begin
        finished = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!finished) begin n_errors++; $display("FAIL rnd_drain: got unfinished expected all transfers done"); end
    req_valid = '0;
    slv_auto = 0;
  endtask

  initial begin
    preset    = 1'b1;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    req_strb  = '0;
    test_reset();
    test_single_write();
    test_single_read_wait();
    test_contention();
    test_slave_error();
    test_timeout();
    test_reset_mid();
    test_random();
    repeat (2) step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish before 500000 ns");
    $fatal(1);
  end

endmodule
